// File: rtl/pixel_capture_buffer.sv
// Double-buffered decimating frame grabber.
// A camera stream is sampled on an IMG_DIM x IMG_DIM grid (origin X0/Y0, pitch STEP).
// Samples are written into the back bank. A complete frame swaps the back bank
// to the front, where the processor reads it with one cycle of latency.
module pixel_capture_buffer #(
  parameter int IMG_DIM = 28,
  parameter int STEP    = 8,
  parameter int X0      = 208,
  parameter int Y0      = 128
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        cam_frame_valid,
  input  logic        cam_line_valid,
  input  logic        cam_pixel_valid,
  input  logic [7:0]  cam_gray,
  input  logic        capture_en,
  input  logic [11:0] read_address,
  output logic [7:0]  pixel,
  output logic        frame_ready,
  output logic        busy
);

  localparam int          NPIX   = IMG_DIM * IMG_DIM;
  localparam int          AW     = $clog2(NPIX);
  localparam logic [11:0] NPIX_W = 12'(NPIX);
  localparam logic [11:0] DIM_W  = 12'(IMG_DIM);
  localparam logic [11:0] STEP_W = 12'(STEP);
  localparam logic [11:0] X0_W   = 12'(X0);
  localparam logic [11:0] Y0_W   = 12'(Y0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_SWAP    = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic        fv_q, lv_q;
  logic        frame_rise, frame_fall, line_fall, pix_stb;
  logic [11:0] col_q, col_d, row_q, row_d;
  logic [11:0] wcnt_q, wcnt_d;
  logic        bank_sel_q, bank_sel_d;
  logic        frame_ready_q, frame_ready_d;
  logic [7:0]  pixel_q, pixel_d;
  logic        swap_now;

  logic [11:0] col_off, row_off, col_idx, row_idx;
  logic        col_hit, row_hit, sample_we;
  logic [AW-1:0] wr_addr, rd_addr;

  logic [7:0] bank0_q [NPIX];
  logic [7:0] bank1_q [NPIX];

  // Edge detection on the camera framing strobes
  always_comb begin
    frame_rise = cam_frame_valid & ~fv_q;
    frame_fall = ~cam_frame_valid & fv_q;
    line_fall  = ~cam_line_valid & lv_q;
    pix_stb    = cam_pixel_valid & cam_line_valid;
  end

  // Source position counters, saturating at 12 bits
  always_comb begin
    col_d = col_q;
    if (line_fall) begin
      col_d = '0;
    end else if (pix_stb && (col_q != '1)) begin
      col_d = col_q + 12'd1;
    end
    row_d = row_q;
    if (frame_rise) begin
      row_d = '0;
    end else if (line_fall && (row_q != '1)) begin
      row_d = row_q + 12'd1;
    end
  end

  // Decimation grid hit test and back-bank address
  always_comb begin
    col_off   = col_q - X0_W;
    row_off   = row_q - Y0_W;
    col_idx   = col_off / STEP_W;
    row_idx   = row_off / STEP_W;
    col_hit   = (col_q >= X0_W) && ((col_off % STEP_W) == 12'd0) && (col_idx < DIM_W);
    row_hit   = (row_q >= Y0_W) && ((row_off % STEP_W) == 12'd0) && (row_idx < DIM_W);
    sample_we = pix_stb && col_hit && row_hit && (state_q == S_CAPTURE);
    wr_addr   = AW'(row_idx) * AW'(DIM_W) + AW'(col_idx);
  end

  // FSM state register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; capture_en only matters at frame start
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (frame_rise && capture_en) state_d = S_CAPTURE;
      S_CAPTURE: if (frame_fall) state_d = (wcnt_q == NPIX_W) ? S_SWAP : S_IDLE;
      S_SWAP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy     = (state_q == S_CAPTURE);
    swap_now = (state_q == S_SWAP);
  end

  // Bank select, sticky ready flag, write count and read data next-state
  always_comb begin
    bank_sel_d    = swap_now ? ~bank_sel_q : bank_sel_q;
    frame_ready_d = frame_ready_q | swap_now;
    wcnt_d        = wcnt_q;
    if (swap_now || (state_q == S_IDLE && frame_rise && capture_en)) begin
      wcnt_d = '0;
    end else if (sample_we && (wcnt_q != '1)) begin
      wcnt_d = wcnt_q + 12'd1;
    end
    rd_addr = read_address[AW-1:0];
    pixel_d = '0;
    if (read_address < NPIX_W) begin
      pixel_d = bank_sel_q ? bank1_q[rd_addr] : bank0_q[rd_addr];
    end
  end

  // Control and datapath registers
  // Frame-valid history resets high so a frame already in flight at reset
  // release does not look like a new frame start.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      fv_q          <= 1'b1;
      lv_q          <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
      wcnt_q        <= '0;
      bank_sel_q    <= 1'b0;
      frame_ready_q <= 1'b0;
      pixel_q       <= '0;
    end else begin
      fv_q          <= cam_frame_valid;
      lv_q          <= cam_line_valid;
      col_q         <= col_d;
      row_q         <= row_d;
      wcnt_q        <= wcnt_d;
      bank_sel_q    <= bank_sel_d;
      frame_ready_q <= frame_ready_d;
      pixel_q       <= pixel_d;
    end
  end

  // Back-bank write; bank contents are deliberately not reset
  always_ff @(posedge clk_clk) begin
    if (sample_we) begin
      if (bank_sel_q) begin
        bank0_q[wr_addr] <= cam_gray;
      end else begin
        bank1_q[wr_addr] <= cam_gray;
      end
    end
  end

  assign pixel       = pixel_q;
  assign frame_ready = frame_ready_q;

endmodule

// File: tb/tb_pixel_capture_buffer.sv
// Directed bench for pixel_capture_buffer using a reduced grid pitch/origin
// so that full frames stay short; the 784-pixel image size is kept.
`timescale 1ns/1ps
module tb_pixel_capture_buffer;

  localparam int DIM  = 28;
  localparam int STP  = 2;
  localparam int XS   = 3;
  localparam int YS   = 2;
  localparam int NCOL = 60;
  localparam int NROW = 58;
  localparam int NPIX = 784;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fv = 1'b0, lv = 1'b0, pv = 1'b0, en = 1'b1;
  logic [7:0]  gray = '0;
  logic [11:0] raddr = '0;
  logic [7:0]  pixel;
  logic        frame_ready, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pixel_capture_buffer #(.IMG_DIM(DIM), .STEP(STP), .X0(XS), .Y0(YS)) dut (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .cam_frame_valid(fv),
    .cam_line_valid (lv),
    .cam_pixel_valid(pv),
    .cam_gray       (gray),
    .capture_en     (en),
    .read_address   (raddr),
    .pixel          (pixel),
    .frame_ready    (frame_ready),
    .busy           (busy)
  );

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    repeat (4) tick();
  endtask

  function automatic logic [7:0] exp_pix(input int a, input int mode, input logic [7:0] cval);
    int i, j, c, r;
    if (a >= NPIX) return 8'h00;
    i = a % DIM;
    j = a / DIM;
    c = XS + STP * i;
    r = YS + STP * j;
    if (mode == 1) return cval;
    return 8'((c ^ r) + cval);
  endfunction

  // Drives one frame; leaves frame_valid low without clocking it in.
  task automatic drive_frame(input int nrows, input int mode, input logic [7:0] cval,
                             input int en_drop_row, input int rst_row,
                             output logic busy_mid, output logic busy_late,
                             output logic rst_busy, output logic rst_fr,
                             output logic [7:0] rst_pix);
    busy_mid = 1'bx; busy_late = 1'bx; rst_busy = 1'bx; rst_fr = 1'bx; rst_pix = 'x;
    fv = 1'b1;
    tick();
    tick();
    for (int r = 0; r < nrows; r++) begin
      if (r == 1) busy_mid = busy;
      if (r == en_drop_row) en = 1'b0;
      if (r == rst_row) begin
        rst_n = 1'b0;
        #1;
        rst_busy = busy;
        rst_fr   = frame_ready;
        rst_pix  = pixel;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
      end
      if (rst_row >= 0 && r == rst_row + 2) busy_late = busy;
      lv = 1'b1;
      for (int c = 0; c < NCOL; c++) begin
        if (c % 16 == 5) begin
          pv = 1'b0;
          gray = 8'hEE;
          tick();
        end
        pv = 1'b1;
        gray = (mode == 1) ? cval : 8'((c ^ r) + cval);
        tick();
      end
      pv = 1'b0;
      lv = 1'b0;
      gray = '0;
      tick();
      tick();
    end
    fv = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    raddr = 12'd784;
    tick();
    tick();
    total++; if (pixel !== 8'h00) begin bad++; $display("FAIL reset_pixel: got %h want 00", pixel); end
    total++; if (frame_ready !== 1'b0) begin bad++; $display("FAIL reset_frame_ready: got %b want 0", frame_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    tick();
    tick();
    total++; if (pixel !== 8'h00) begin bad++; $display("FAIL pre_ready_oob_read: got %h want 00", pixel); end
  endtask

  task automatic test_truncated;
    logic bm, bl, rb, rf;
    logic [7:0] rp;
    en = 1'b1;
    drive_frame(30, 0, 8'h00, -1, -1, bm, bl, rb, rf, rp);
    total++; if (bm !== 1'b1) begin bad++; $display("FAIL trunc_busy_mid: got %b want 1", bm); end
    settle();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL trunc_busy_after: got %b want 0", busy); end
    total++; if (frame_ready !== 1'b0) begin bad++; $display("FAIL trunc_frame_ready: got %b want 0", frame_ready); end
  endtask

  task automatic test_full_frame;
    logic bm, bl, rb, rf;
    logic [7:0] rp, e;
    drive_frame(NROW, 0, 8'h00, -1, -1, bm, bl, rb, rf, rp);
    total++; if (bm !== 1'b1) begin bad++; $display("FAIL full_busy_mid: got %b want 1", bm); end
    settle();
    total++; if (frame_ready !== 1'b1) begin bad++; $display("FAIL full_frame_ready: got %b want 1", frame_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_busy_after: got %b want 0", busy); end
    for (int a = 0; a < NPIX; a++) begin
      raddr = 12'(a);
      tick();
      e = exp_pix(a, 0, 8'h00);
      total++; if (pixel !== e) begin bad++; $display("FAIL full_pix[%0d]: got %h want %h", a, pixel, e); end
    end
  endtask

  task automatic test_oob_read;
    int addrs [6] = '{783, 784, 0, 4095, 1000, 27};
    logic [7:0] e;
    foreach (addrs[k]) begin
      raddr = 12'(addrs[k]);
      tick();
      e = exp_pix(addrs[k], 0, 8'h00);
      total++; if (pixel !== e) begin bad++; $display("FAIL oob_read[%0d]: got %h want %h", addrs[k], pixel, e); end
    end
  endtask

  task automatic test_back_to_back;
    logic bm, bl, rb, rf;
    logic [7:0] rp;
    int addrs [3] = '{0, 392, 783};
    drive_frame(NROW, 1, 8'h11, -1, -1, bm, bl, rb, rf, rp);
    settle();
    foreach (addrs[k]) begin
      raddr = 12'(addrs[k]);
      tick();
      total++; if (pixel !== 8'h11) begin bad++; $display("FAIL frameA_pix[%0d]: got %h want 11", addrs[k], pixel); end
    end
    raddr = 12'd100;
    drive_frame(NROW, 1, 8'h22, -1, -1, bm, bl, rb, rf, rp);
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL swap_busy: got %b want 0", busy); end
    fv = 1'b1;
    tick();
    total++; if (pixel !== 8'h11) begin bad++; $display("FAIL swap_cycle_read: got %h want 11", pixel); end
    tick();
    total++; if (pixel !== 8'h22) begin bad++; $display("FAIL post_swap_read: got %h want 22", pixel); end
    drive_frame(NROW, 1, 8'h33, -1, -1, bm, bl, rb, rf, rp);
    total++; if (bm !== 1'b0) begin bad++; $display("FAIL swap_rise_ignored_busy: got %b want 0", bm); end
    settle();
    total++; if (pixel !== 8'h22) begin bad++; $display("FAIL swap_rise_ignored_pix: got %h want 22", pixel); end
    foreach (addrs[k]) begin
      raddr = 12'(addrs[k]);
      tick();
      total++; if (pixel !== 8'h22) begin bad++; $display("FAIL frameB_pix[%0d]: got %h want 22", addrs[k], pixel); end
    end
  endtask

  task automatic test_capture_en;
    logic bm, bl, rb, rf;
    logic [7:0] rp;
    int addrs [3] = '{0, 500, 783};
    en = 1'b0;
    drive_frame(NROW, 1, 8'h44, -1, -1, bm, bl, rb, rf, rp);
    total++; if (bm !== 1'b0) begin bad++; $display("FAIL en_low_busy: got %b want 0", bm); end
    settle();
    foreach (addrs[k]) begin
      raddr = 12'(addrs[k]);
      tick();
      total++; if (pixel !== 8'h22) begin bad++; $display("FAIL en_low_front[%0d]: got %h want 22", addrs[k], pixel); end
    end
    en = 1'b1;
    drive_frame(NROW, 1, 8'h55, 5, -1, bm, bl, rb, rf, rp);
    total++; if (bm !== 1'b1) begin bad++; $display("FAIL en_drop_busy: got %b want 1", bm); end
    settle();
    foreach (addrs[k]) begin
      raddr = 12'(addrs[k]);
      tick();
      total++; if (pixel !== 8'h55) begin bad++; $display("FAIL en_drop_pix[%0d]: got %h want 55", addrs[k], pixel); end
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid_capture;
    logic bm, bl, rb, rf;
    logic [7:0] rp, e;
    raddr = 12'd0;
    tick();
    total++; if (pixel !== 8'h55) begin bad++; $display("FAIL pre_reset_pix: got %h want 55", pixel); end
    drive_frame(NROW, 0, 8'h07, -1, 10, bm, bl, rb, rf, rp);
    total++; if (bm !== 1'b1) begin bad++; $display("FAIL rst_busy_before: got %b want 1", bm); end
    total++; if (rb !== 1'b0) begin bad++; $display("FAIL rst_busy_async: got %b want 0", rb); end
    total++; if (rf !== 1'b0) begin bad++; $display("FAIL rst_frame_ready_async: got %b want 0", rf); end
    total++; if (rp !== 8'h00) begin bad++; $display("FAIL rst_pixel_async: got %h want 00", rp); end
    total++; if (bl !== 1'b0) begin bad++; $display("FAIL rst_busy_after_release: got %b want 0", bl); end
    settle();
    total++; if (frame_ready !== 1'b0) begin bad++; $display("FAIL rst_partial_no_swap: got %b want 0", frame_ready); end
    drive_frame(NROW, 0, 8'h09, -1, -1, bm, bl, rb, rf, rp);
    total++; if (bm !== 1'b1) begin bad++; $display("FAIL post_rst_busy: got %b want 1", bm); end
    settle();
    total++; if (frame_ready !== 1'b1) begin bad++; $display("FAIL post_rst_frame_ready: got %b want 1", frame_ready); end
    for (int a = 0; a < NPIX; a++) begin
      raddr = 12'(a);
      tick();
      e = exp_pix(a, 0, 8'h09);
      total++; if (pixel !== e) begin bad++; $display("FAIL post_rst_pix[%0d]: got %h want %h", a, pixel, e); end
    end
  endtask

  initial begin
    test_reset();
    test_truncated();
    test_full_frame();
    test_oob_read();
    test_back_to_back();
    test_capture_en();
    test_reset_mid_capture();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
